conversor_bin_bcd: RTL and testbench
====================================

CONVERSOR_BIN_BCD -- requirements
Module: conversor_bin_bcd

Interface
REQ-001 SHALL have parameter LARG, default 14, meaning binary input width in bits.
REQ-002 SHALL have parameter MAX_DEC, default 9999, meaning the largest value representable on four decimal digits.
REQ-003 SHALL have port clk, input, 1, the single system clock; all state changes on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port binario, input, LARG, unsigned value to convert.
REQ-006 SHALL have port inicio, input, 1, start request.
REQ-007 SHALL have port ocupado, output, 1, conversion in progress.
REQ-008 SHALL have port pronto, output, 1, single-cycle result-valid pulse.
REQ-009 SHALL have port estouro, output, 1, last captured value exceeded MAX_DEC.
REQ-010 SHALL have ports bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade, output, 4 each, registered BCD digits that drive one display decoder per digit.

Function
REQ-011 SHALL implement FSM states OCIOSO, DESLOCA, FIM; the reset state is OCIOSO.
REQ-012 OCIOSO: when inicio=1, the block SHALL capture binario, clear the scratch BCD register and iteration counter, and go to DESLOCA; ocupado SHALL be 1 from the next cycle.
REQ-013 DESLOCA: each cycle the block SHALL first add 3 to every scratch nibble >= 5, then shift {scratch, shift register} left by 1 bit; it SHALL do this for exactly LARG cycles, then go to FIM.
REQ-014 FIM: the block SHALL load the four output digits from scratch, assert pronto for exactly one cycle, deassert ocupado, and return to OCIOSO.
REQ-015 Latency SHALL be fixed: pronto is high on the (LARG+2)th rising edge after the edge that sampled inicio=1, i.e. 16 cycles for LARG=14, independent of the value.
REQ-016 inicio SHALL be ignored in DESLOCA and FIM, with no restart and no queuing.
REQ-017 Output digits and estouro SHALL hold their values between completions and change only in FIM.
REQ-018 The overflow check SHALL be made at capture: if binario > MAX_DEC, estouro SHALL be 1 at completion and all four digits SHALL be 4'hE, so the display shows "EEEE"; otherwise estouro SHALL be 0.
REQ-019 An overflowed conversion SHALL still take the full fixed latency.
REQ-020 Scratch BCD width SHALL be 16 bits; no nibble SHALL ever exceed 9 after adjustment when the input is <= MAX_DEC.
REQ-021 binario changing after capture SHALL have no effect on the conversion in progress.

Reset
REQ-022 While rst_n=0, the block SHALL force, asynchronously: state OCIOSO, ocupado=0, pronto=0, estouro=0, all digits 4'h0, counter and scratch registers 0.
REQ-023 Reset asserted during DESLOCA or FIM SHALL abort the conversion; no pronto SHALL follow, and the outputs SHALL read as in REQ-022.
REQ-024 The first inicio sampled after rst_n deasserts SHALL be accepted normally.

Structure
REQ-025 A shared package/header SHALL hold: the FSM state encodings, the default LARG, MAX_DEC, and the overflow digit code 4'hE.
REQ-026 The add-3 correction SHALL be a combinational sub-module ajuste_bcd (4-bit in, 4-bit out, adds 3 if >= 5), instantiated four times.
REQ-027 The iteration counter SHALL be sized to hold LARG, using clog2 of LARG+1 bits.

Verification
REQ-028 Reset release, then binario=0 with a 1-cycle inicio -> pronto on the 16th edge; digits 0,0,0,0; estouro=0.
REQ-029 binario=1234 -> digits 1,2,3,4; ocupado high for exactly the conversion cycles; pronto width 1 cycle.
REQ-030 binario=9999 then binario=10000 -> first gives 9,9,9,9 with estouro=0; second gives E,E,E,E with estouro=1, at the same latency.
REQ-031 Start 4095, then pulse inicio with 77 at cycle 5 of the conversion -> the result is 4,0,9,5 and no second pronto occurs.
REQ-032 Start 5678, assert rst_n=0 at cycle 8 -> all outputs read 0 immediately and no pronto follows; after release, start 42 -> 0,0,4,2.
REQ-033 Random sweep of 0..16383 compared against a reference model -> all results match and latency is always 16.

Source files
------------

// File: rtl/conversor_bin_bcd_pkg.sv
// Shared definitions for the binary-to-BCD converter: FSM states, defaults
// and the digit code shown on the displays when the value does not fit.
package conversor_bin_bcd_pkg;

  typedef enum logic [1:0] {
    OCIOSO  = 2'd0,
    DESLOCA = 2'd1,
    FIM     = 2'd2
  } estado_t;

  localparam int unsigned LARG_PADRAO    = 14;
  localparam int unsigned MAX_DEC_PADRAO = 9999;
  localparam int unsigned LARG_BCD       = 16;
  localparam logic [3:0]  DIGITO_ESTOURO = 4'hE;

endpackage

// File: rtl/conversor_bin_bcd_ajuste_bcd.sv
// Double-dabble nibble correction: adds 3 to a BCD nibble that is 5 or more,
// so the following left shift carries correctly into the next decimal digit.
module ajuste_bcd (
  input  logic [3:0] entrada,
  output logic [3:0] saida
);

  always_comb begin
    saida = entrada;
    if (entrada >= 4'd5) saida = entrada + 4'd3;
  end

endmodule

// File: rtl/conversor_bin_bcd.sv
// Sequential binary-to-BCD converter (shift-and-add-3), fixed latency of
// LARG+2 cycles, with "EEEE" shown when the input exceeds MAX_DEC.
module conversor_bin_bcd
  import conversor_bin_bcd_pkg::*;
#(
  parameter int unsigned LARG    = LARG_PADRAO,
  parameter int unsigned MAX_DEC = MAX_DEC_PADRAO
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [LARG-1:0] binario,
  input  logic            inicio,
  output logic            ocupado,
  output logic            pronto,
  output logic            estouro,
  output logic [3:0]      bcd_milhar,
  output logic [3:0]      bcd_centena,
  output logic [3:0]      bcd_dezena,
  output logic [3:0]      bcd_unidade
);

  localparam int unsigned    CW     = $clog2(LARG + 1);
  localparam logic [CW-1:0]  ULTIMO = CW'(LARG - 1);

  estado_t               estado, prox;
  logic [LARG-1:0]       desloc;
  logic [LARG_BCD-1:0]   scratch;
  logic [LARG_BCD-1:0]   ajustado;
  logic [CW-1:0]         cont;
  logic                  estouro_cap;

  for (genvar g = 0; g < 4; g++) begin : g_ajuste
    ajuste_bcd u_ajuste (
      .entrada (scratch[4*g +: 4]),
      .saida   (ajustado[4*g +: 4])
    );
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) estado <= OCIOSO;
    else        estado <= prox;
  end

  always_comb begin
    prox = estado;
    unique case (estado)
      OCIOSO:  if (inicio) prox = DESLOCA;
      DESLOCA: if (cont == ULTIMO) prox = FIM;
      FIM:     prox = OCIOSO;
      default: prox = OCIOSO;
    endcase
  end

  assign ocupado = (estado != OCIOSO);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      desloc      <= '0;
      scratch     <= '0;
      cont        <= '0;
      estouro_cap <= 1'b0;
      pronto      <= 1'b0;
      estouro     <= 1'b0;
      bcd_milhar  <= '0;
      bcd_centena <= '0;
      bcd_dezena  <= '0;
      bcd_unidade <= '0;
    end else begin
      pronto <= 1'b0;
      unique case (estado)
        OCIOSO: begin
          if (inicio) begin
            desloc      <= binario;
            scratch     <= '0;
            cont        <= '0;
            estouro_cap <= (32'(binario) > MAX_DEC);
          end
        end
        DESLOCA: begin
          // correction is applied before the shift so the final shift needs no fix-up
          {scratch, desloc} <= {ajustado[LARG_BCD-2:0], desloc, 1'b0};
          cont              <= cont + 1'b1;
        end
        FIM: begin
          pronto      <= 1'b1;
          estouro     <= estouro_cap;
          bcd_milhar  <= estouro_cap ? DIGITO_ESTOURO : scratch[15:12];
          bcd_centena <= estouro_cap ? DIGITO_ESTOURO : scratch[11:8];
          bcd_dezena  <= estouro_cap ? DIGITO_ESTOURO : scratch[7:4];
          bcd_unidade <= estouro_cap ? DIGITO_ESTOURO : scratch[3:0];
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_conversor_bin_bcd.sv
// Scoreboard bench for conversor_bin_bcd: stimulus pushes decimal reference
// results, a negedge monitor pops and compares on every pronto pulse.
module tb_conversor_bin_bcd;

  localparam int unsigned LARG    = 14;
  localparam int unsigned MAX_DEC = 9999;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic [LARG-1:0] binario = '0;
  logic            inicio = 1'b0;
  logic            ocupado, pronto, estouro;
  logic [3:0]      bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade;

  conversor_bin_bcd #(.LARG(LARG), .MAX_DEC(MAX_DEC)) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .binario     (binario),
    .inicio      (inicio),
    .ocupado     (ocupado),
    .pronto      (pronto),
    .estouro     (estouro),
    .bcd_milhar  (bcd_milhar),
    .bcd_centena (bcd_centena),
    .bcd_dezena  (bcd_dezena),
    .bcd_unidade (bcd_unidade)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] dig;
    logic        est;
    int unsigned cap;
  } esperado_t;

  esperado_t   sb[$];
  int unsigned cyc = 0;
  int unsigned checks = 0;
  int unsigned errors = 0;

  always @(posedge clk) cyc++;

  task automatic chk(input string nome, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", nome, got, exp, $time);
    end
  endtask

  function automatic esperado_t modelo(input int unsigned v, input int unsigned cap);
    esperado_t e;
    e.cap = cap;
    if (v > MAX_DEC) begin
      e.est = 1'b1;
      e.dig = 16'hEEEE;
    end else begin
      e.est = 1'b0;
      e.dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
    end
    return e;
  endfunction

  logic [15:0] ult_dig = '0;
  logic        ult_est = 1'b0;
  logic        pronto_ant = 1'b0;
  int unsigned ocup_cnt = 0;

  always @(negedge clk) begin
    if (!rst_n) begin
      ult_dig    = '0;
      ult_est    = 1'b0;
      pronto_ant = 1'b0;
      ocup_cnt   = 0;
    end else begin
      if (ocupado) ocup_cnt++;
      if (pronto) begin
        chk("largura_pronto", 32'(pronto_ant), 32'd0);
        if (sb.size() == 0) begin
          chk("pronto_inesperado", 32'(pronto), 32'd0);
        end else begin
          esperado_t e;
          e = sb.pop_front();
          chk("digitos", {16'd0, bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade}, {16'd0, e.dig});
          chk("estouro", 32'(estouro), 32'(e.est));
          // pronto visible after edge cap+LARG+1, i.e. high at the (LARG+2)th edge
          chk("latencia", cyc - e.cap, LARG + 1);
          chk("ocupado_ciclos", ocup_cnt, LARG + 1);
          chk("ocupado_no_pronto", 32'(ocupado), 32'd0);
        end
        ocup_cnt = 0;
        ult_dig  = {bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade};
        ult_est  = estouro;
      end else begin
        chk("saidas_mantidas", {15'd0, estouro, bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade},
            {15'd0, ult_est, ult_dig});
      end
      pronto_ant = pronto;
    end
  end

  task automatic iniciar(input int unsigned v);
    @(negedge clk);
    binario = LARG'(v);
    inicio  = 1'b1;
    sb.push_back(modelo(v, cyc + 1));
    @(negedge clk);
    inicio  = 1'b0;
    binario = LARG'($urandom);
  endtask

  task automatic aguardar();
    for (int i = 0; i < 40 && sb.size() != 0; i++) @(negedge clk);
    @(negedge clk);
    if (sb.size() != 0) begin
      chk("timeout_pronto", sb.size(), 0);
      sb.delete();
    end
  endtask

  task automatic converter(input int unsigned v);
    iniciar(v);
    aguardar();
  endtask

  task automatic checar_zerado(input string nome);
    chk(nome, {22'd0, ocupado, pronto, estouro, bcd_milhar, bcd_centena, bcd_dezena, bcd_unidade}, 32'd0);
  endtask

  initial begin
    #4_000_000;
    $display("FAIL watchdog: simulation did not finish, checks=%0d", checks);
    $fatal(1, "watchdog");
  end

  initial begin
    repeat (3) @(negedge clk);
    checar_zerado("reset_inicial");
    rst_n = 1'b1;
    @(negedge clk);
    checar_zerado("apos_liberar_reset");

    converter(0);
    converter(1234);
    converter(9999);
    converter(10000);
    converter(16383);

    iniciar(4095);
    repeat (4) @(negedge clk);
    binario = LARG'(77);
    inicio  = 1'b1;
    @(negedge clk);
    inicio  = 1'b0;
    aguardar();
    repeat (20) @(negedge clk);

    iniciar(5678);
    repeat (7) @(negedge clk);
    #2 rst_n = 1'b0;
    #1 checar_zerado("reset_assincrono");
    sb.delete();
    repeat (3) @(negedge clk);
    checar_zerado("durante_reset");
    rst_n = 1'b1;
    repeat (20) @(negedge clk);
    checar_zerado("sem_pronto_apos_abort");
    converter(42);

    for (int n = 0; n < 60; n++) begin
      int unsigned v;
      v = ($urandom % 2 == 0) ? $urandom_range(0, 16383) : $urandom_range(0, MAX_DEC);
      repeat ($urandom_range(0, 3)) @(negedge clk);
      converter(v);
    end
    converter(MAX_DEC);
    converter(MAX_DEC + 1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
